osc_burst_ctrl: RTL
===================

# osc_burst_ctrl

Synchronous controller that sequences the enable input `E` of the ring `Oscillator` to produce programmed bursts of oscillation. It counts `F` rising edges per burst, inserts idle gaps between bursts, and detects a stalled oscillator with a timeout. It sits between the system-clocked control logic and the free-running `Oscillator`, and is the only driver of that oscillator's `E`.

## Interface
- `CNT_W`, 8, width of the edge-count, burst-count and gap fields
- `TO_W`, 12, width of the timeout field
- `SYNC_STAGES`, 2, flip-flop stages in the `F` synchronizer (minimum 2)

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle request; honoured only in IDLE or ERR
- `abort`  in  1  forces IDLE; takes priority over every input except `rst_n`
- `pulses`  in  CNT_W  `F` rising edges per burst; sampled on `start`
- `bursts`  in  CNT_W  number of bursts; sampled on `start`
- `gap`  in  CNT_W  clk cycles with `E`=0 between bursts; sampled on `start`
- `timeout`  in  TO_W  maximum clk cycles between counted edges; 0 disables; sampled on `start`
- `F`  in  1  oscillator output; asynchronous to `clk`
- `E`  out  1  oscillator enable; registered
- `busy`  out  1  high in RUN and GAP
- `done`  out  1  one-cycle pulse on normal completion
- `err`  out  1  level; high in ERR
- `edge_cnt`  out  CNT_W  edges counted in the current burst
- `burst_idx`  out  CNT_W  index of the current burst, 0-based

## Operation
- Reset values: every output is 0, state is IDLE, and the synchronizer flops are cleared.
- `F` passes through `SYNC_STAGES` flops followed by a one-flop rising-edge detector. Detected edges count only in RUN; edges in GAP, IDLE or ERR are ignored, including trailing edges after `E` falls.
- States: IDLE, RUN, GAP, ERR.
- **IDLE**
  - On `start`: latch the configuration, clear `edge_cnt` and `burst_idx`, and go to RUN.
  - If `pulses`==0 or `bursts`==0: stay in IDLE, pulse `done` the next cycle, and never assert `E`.
- **RUN**
  - `E`=1. Each detected edge increments `edge_cnt` and clears the timeout counter.
  - When `edge_cnt` reaches `pulses` and `burst_idx`==`bursts`-1: go to IDLE and pulse `done`.
  - When `edge_cnt` reaches `pulses` and more bursts remain: go to GAP.
- **GAP**
  - `E`=0 for max(`gap`,1) cycles.
  - Then increment `burst_idx`, clear `edge_cnt`, and go to RUN.
- **Timeout (RUN only)**
  - The timeout counter clears on RUN entry and on each counted edge.
  - If it reaches `timeout` (nonzero) with no edge, go to ERR.
  - If an edge and the timeout occur in the same cycle, the edge wins.
- **ERR**
  - `E`=0, `err`=1, and `edge_cnt`/`burst_idx` are frozen for debug.
  - `start` clears `err` and behaves as in IDLE. `abort` clears `err` and goes to IDLE.
- **`abort`**: from any state, the next cycle has IDLE, `E`=0, `busy`=0, no `done`, and counters cleared.
- **`start` while busy**: ignored, and the configuration is not re-sampled.
- **Counter widths**: `edge_cnt` never exceeds `pulses` and never wraps. The timeout counter saturates at `timeout`.

## Timing
- `start` sampled at edge n: `E`=1 and `busy`=1 from cycle n+1.
- `F` rises: the edge is counted `SYNC_STAGES`+1 cycles later (3 clk by default), ±1 cycle of synchronizer uncertainty.
- Final edge counted at edge k:
  - `E`=0 from cycle k+1.
  - If it is the last burst, `done`=1 in cycle k+1 only and `busy`=0 from k+1.
- GAP entered at k+1: `E` re-asserts at cycle k+1+max(`gap`,1).
- Timeout with `timeout`=T: `err` rises T+1 cycles after the last counted edge (or after RUN entry).
- `rst_n` low mid-burst: `E` drops asynchronously and all outputs return to 0 immediately.

## Test plan
- `pulses`=4, `bursts`=1, `gap`=0, `timeout`=0, with `F` toggling every 5 clk:
  - `E` high from the cycle after `start`.
  - `E` falls and `done` pulses for one cycle 1 cycle after the 4th edge is counted.
  - Final value `edge_cnt`=4.
- `pulses`=2, `bursts`=3, `gap`=6:
  - Three `E` high windows, each separated by exactly 6 low cycles.
  - `burst_idx` steps 0,1,2; a single `done` at the end.
- `timeout`=20, `pulses`=5, with `F` stuck low after 2 edges:
  - `err`=1 and `E`=0 exactly 21 cycles after the 2nd counted edge.
  - Frozen values `edge_cnt`=2 and `busy`=0.
  - A following `start` clears `err` and restarts.
- `abort` in mid-RUN and again in mid-GAP:
  - Next cycle: `E`=0, `busy`=0, counters 0.
  - No `done` pulse.
  - A `start` pulse issued during the burst has no effect.
- `pulses`=0 with `start`: `done` pulses 1 cycle later and `E` never rises.
- `F` glitching during GAP, and `rst_n` low asynchronously mid-RUN:
  - Glitch edges are not counted.
  - All outputs are 0 immediately on reset, and the next `start` begins from burst 0.

Source files
------------

// File: rtl/osc_burst_ctrl.sv
// Burst sequencer for a free-running ring oscillator: drives its enable E,
// counts synchronized F edges per burst, spaces bursts with gaps, and flags stalls.
module osc_burst_ctrl #(
  parameter int CNT_W       = 8,
  parameter int TO_W        = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] pulses,
  input  logic [CNT_W-1:0] bursts,
  input  logic [CNT_W-1:0] gap,
  input  logic [TO_W-1:0]  timeout,
  input  logic             F,
  output logic             E,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] edge_cnt,
  output logic [CNT_W-1:0] burst_idx
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP, S_ERR} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [TO_W-1:0]  TO_ONE  = TO_W'(1);

  state_t r_state;
  state_t w_nextState;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_fPrev;
  logic                   w_edge;

  logic [CNT_W-1:0] r_pulses;
  logic [CNT_W-1:0] r_bursts;
  logic [CNT_W-1:0] r_gap;
  logic [TO_W-1:0]  r_timeout;

  logic [CNT_W-1:0] r_edgeCnt;
  logic [CNT_W-1:0] w_edgeCnt;
  logic [CNT_W-1:0] r_burstIdx;
  logic [CNT_W-1:0] w_burstIdx;
  logic [CNT_W-1:0] r_gapCnt;
  logic [CNT_W-1:0] w_gapCnt;
  logic [CNT_W-1:0] w_gapLast;
  logic [TO_W-1:0]  r_toCnt;
  logic [TO_W-1:0]  w_toCnt;

  logic w_load;
  logic w_done;

  logic r_e;
  logic r_busy;
  logic r_done;
  logic r_err;

  // F is asynchronous to clk; only the last synchronizer stage feeds the edge detector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= '0;
      r_fPrev <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], F};
      r_fPrev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_edge = r_sync[SYNC_STAGES-1] & ~r_fPrev;

  // A zero gap still spends one cycle with E low between bursts.
  assign w_gapLast = (r_gap == '0) ? '0 : (r_gap - CNT_ONE);

  always_comb begin
    w_nextState = r_state;
    w_edgeCnt   = r_edgeCnt;
    w_burstIdx  = r_burstIdx;
    w_toCnt     = r_toCnt;
    w_gapCnt    = r_gapCnt;
    w_load      = 1'b0;
    w_done      = 1'b0;

    if (abort) begin
      w_nextState = S_IDLE;
      w_edgeCnt   = '0;
      w_burstIdx  = '0;
      w_toCnt     = '0;
      w_gapCnt    = '0;
    end else begin
      case (r_state)
        S_IDLE, S_ERR: begin
          if (start) begin
            w_load     = 1'b1;
            w_edgeCnt  = '0;
            w_burstIdx = '0;
            w_toCnt    = '0;
            w_gapCnt   = '0;
            if ((pulses == '0) || (bursts == '0)) begin
              w_nextState = S_IDLE;
              w_done      = 1'b1;
            end else begin
              w_nextState = S_RUN;
            end
          end
        end
        S_RUN: begin
          // Completion is checked before edges so edge_cnt can never pass pulses.
          if (r_edgeCnt == r_pulses) begin
            if (r_burstIdx == (r_bursts - CNT_ONE)) begin
              w_nextState = S_IDLE;
              w_done      = 1'b1;
            end else begin
              w_nextState = S_GAP;
              w_gapCnt    = '0;
            end
          end else if (w_edge) begin
            w_edgeCnt = r_edgeCnt + CNT_ONE;
            w_toCnt   = '0;
          end else if (r_toCnt == r_timeout) begin
            if (r_timeout != '0) begin
              w_nextState = S_ERR;
            end
          end else begin
            w_toCnt = r_toCnt + TO_ONE;
          end
        end
        S_GAP: begin
          if (r_gapCnt == w_gapLast) begin
            w_nextState = S_RUN;
            w_burstIdx  = r_burstIdx + CNT_ONE;
            w_edgeCnt   = '0;
            w_toCnt     = '0;
          end else begin
            w_gapCnt = r_gapCnt + CNT_ONE;
          end
        end
        default: begin
          w_nextState = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_edgeCnt  <= '0;
      r_burstIdx <= '0;
      r_toCnt    <= '0;
      r_gapCnt   <= '0;
    end else begin
      r_state    <= w_nextState;
      r_edgeCnt  <= w_edgeCnt;
      r_burstIdx <= w_burstIdx;
      r_toCnt    <= w_toCnt;
      r_gapCnt   <= w_gapCnt;
    end
  end

  // Configuration is captured only when a start is actually accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pulses  <= '0;
      r_bursts  <= '0;
      r_gap     <= '0;
      r_timeout <= '0;
    end else if (w_load) begin
      r_pulses  <= pulses;
      r_bursts  <= bursts;
      r_gap     <= gap;
      r_timeout <= timeout;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_e    <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_e    <= (w_nextState == S_RUN);
      r_busy <= (w_nextState == S_RUN) || (w_nextState == S_GAP);
      r_done <= w_done;
      r_err  <= (w_nextState == S_ERR);
    end
  end

  assign E         = r_e;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign edge_cnt  = r_edgeCnt;
  assign burst_idx = r_burstIdx;

endmodule
